field_sum_cal: RTL and testbench



---
 rtl/field_sum_cal.sv | 241 ++++++++++++++++++++++++
 tb/tb_field_sum_cal.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_sum_cal.sv
// -----------------------------------------------------------------------------
// field_sum_cal
//
// Parametrised field-sum calculator. A latched DATA_W-bit word is split into
// N = DATA_W/FIELD_W fields; the block outputs field 0 plus a selected field,
// registered. It also runs an automatic sweep that emits every pairwise sum
// f0+f1 .. f0+f(N-1) on consecutive cycles.
//
// Optional feature macro: FIELD_SUM_ALL_EN
//   When defined, sel == N in IDLE returns the sum of all N fields.
//   When undefined, sel == N is treated as an out-of-range select and no
//   all-field adder is built.
//
// Reset is synchronous and active-low.
// -----------------------------------------------------------------------------
module field_sum_cal #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 4,
    // Derived values; not meant to be overridden.
    localparam int N      = DATA_W / FIELD_W,
    localparam int SEL_W  = $clog2(N + 1),
    localparam int OUT_W  = FIELD_W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sweep,
    output logic [OUT_W-1:0]  out,
    output logic              validout,
    output logic [SEL_W-1:0]  fld_idx,
    output logic              busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    // Index constants sized to the select bus, so comparisons stay width-clean.
    localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
`ifdef FIELD_SUM_ALL_EN
    localparam logic [SEL_W-1:0] SEL_ALL  = SEL_W'(N);
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_dreg;
    logic [SEL_W-1:0]    r_idx;
    logic [OUT_W-1:0]    r_out;
    logic                r_valid;
    logic [SEL_W-1:0]    r_fld_idx;
    logic                r_busy;

    logic [DATA_W-1:0]   w_dreg_nxt;
    logic [SEL_W-1:0]    w_idx_nxt;
    logic [OUT_W-1:0]    w_out_nxt;
    logic                w_valid_nxt;
    logic [SEL_W-1:0]    w_fld_idx_nxt;
    logic                w_busy_nxt;

    // ------------------------------------------------------------------------
    // Field extraction and arithmetic
    // ------------------------------------------------------------------------
    logic [FIELD_W-1:0]  w_field [N];
    logic [SEL_W-1:0]    w_pick_idx;
    logic [FIELD_W-1:0]  w_pick_field;
    logic [OUT_W-1:0]    w_pair_sum;
    logic                w_last_idx;

    // Slice the latched word into its fields; field k is the k-th lowest slice.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_field[k] = r_dreg[k*FIELD_W +: FIELD_W];
        end
    end

    // The sweep walks its own index; in IDLE the external select picks the field.
    assign w_pick_idx = (r_state == S_SWEEP) ? r_idx : sel;

    // Multiplex the chosen field; indices outside 0..N-1 yield zero and are
    // never used as a result by the decode below.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_pick_field = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick_idx == SEL_W'(k)) begin
                w_pick_field = w_field[k];
            end
        end
    end

    // Operands are zero-extended to OUT_W, which is wide enough never to overflow.
    assign w_pair_sum = OUT_W'(w_field[0]) + OUT_W'(w_pick_field);
    assign w_last_idx = (r_idx == SEL_LAST);

`ifdef FIELD_SUM_ALL_EN
    logic [OUT_W-1:0]    w_all_sum;

    // Accumulate every field of the latched word for the all-field select.
    always_comb begin
        w_all_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_all_sum = w_all_sum + OUT_W'(w_field[k]);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Hold the current mode; reset always returns to IDLE, even mid-sweep.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Enter SWEEP on a sampled sweep request; leave after the last field.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (sweep) begin
                    w_state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (w_last_idx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / datapath next-value logic
    // ------------------------------------------------------------------------
    // Decode the per-state register updates; anything not written holds.
    always_comb begin
        w_dreg_nxt    = r_dreg;
        w_idx_nxt     = r_idx;
        w_out_nxt     = r_out;
        w_valid_nxt   = r_valid;
        w_fld_idx_nxt = r_fld_idx;
        w_busy_nxt    = r_busy;

        unique case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (sweep) begin
                    // Sweep request wins over sel; fld_idx keeps its last value.
                    w_dreg_nxt  = d;
                    w_idx_nxt   = SEL_ONE;
                    w_busy_nxt  = 1'b1;
                    w_out_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (sel == SEL_ZERO) begin
                    // Latch a new word; its sums are available from the next cycle.
                    w_dreg_nxt    = d;
                    w_out_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_fld_idx_nxt = SEL_ZERO;
                end else if (sel <= SEL_LAST) begin
                    w_out_nxt     = w_pair_sum;
                    w_valid_nxt   = 1'b1;
                    w_fld_idx_nxt = sel;
`ifdef FIELD_SUM_ALL_EN
                end else if (sel == SEL_ALL) begin
                    w_out_nxt     = w_all_sum;
                    w_valid_nxt   = 1'b1;
                    w_fld_idx_nxt = SEL_ALL;
`endif
                end else begin
                    // Out-of-range select: no result, but report what was asked.
                    w_out_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_fld_idx_nxt = sel;
                end
            end
            S_SWEEP: begin
                // Inputs are ignored and dreg is frozen while sweeping.
                w_out_nxt     = w_pair_sum;
                w_valid_nxt   = 1'b1;
                w_fld_idx_nxt = r_idx;
                if (w_last_idx) begin
                    w_busy_nxt = 1'b0;
                end else begin
                    w_idx_nxt  = r_idx + SEL_ONE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Register the decoded values; synchronous reset clears word and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dreg    <= '0;
            r_idx     <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_fld_idx <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_dreg    <= w_dreg_nxt;
            r_idx     <= w_idx_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_fld_idx <= w_fld_idx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign out      = r_out;
    assign validout = r_valid;
    assign fld_idx  = r_fld_idx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_field_sum_cal.sv
// -----------------------------------------------------------------------------
// tb_field_sum_cal
//
// Directed and random stimulus for field_sum_cal at default parameters
// (N=4, OUT_W=6). Expected values come from a transaction-level model: a
// sweep is represented as a queue of pending results computed from plain
// field arithmetic at the moment the sweep starts. Honours FIELD_SUM_ALL_EN.
// -----------------------------------------------------------------------------
module tb_field_sum_cal;

    localparam int DATA_W  = 16;
    localparam int FIELD_W = 4;
    localparam int N       = DATA_W / FIELD_W;
    localparam int SEL_W   = $clog2(N + 1);
    localparam int OUT_W   = FIELD_W + $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  sel;
    logic              sweep;
    logic [OUT_W-1:0]  out;
    logic              validout;
    logic [SEL_W-1:0]  fld_idx;
    logic              busy;

    int total = 0;
    int bad   = 0;

    field_sum_cal #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .sel      (sel),
        .sweep    (sweep),
        .out      (out),
        .validout (validout),
        .fld_idx  (fld_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned sum;
        int unsigned idx;
    } res_t;

    res_t              m_pending[$];
    logic [DATA_W-1:0] m_word;
    int unsigned       m_out;
    int unsigned       m_valid;
    int unsigned       m_fld;
    int unsigned       m_busy;

    function automatic int unsigned field_of(input logic [DATA_W-1:0] w, input int k);
        return (int'(w) >> (k * FIELD_W)) & ((1 << FIELD_W) - 1);
    endfunction

    task automatic model_update(input logic [DATA_W-1:0] d_i, input int sel_i,
                                input bit sw_i, input bit rst_i);
        res_t r;
        if (!rst_i) begin
            m_pending.delete();
            m_word  = '0;
            m_out   = 0;
            m_valid = 0;
            m_fld   = 0;
            m_busy  = 0;
        end else if (m_pending.size() > 0) begin
            r       = m_pending.pop_front();
            m_out   = r.sum;
            m_valid = 1;
            m_fld   = r.idx;
            m_busy  = (m_pending.size() > 0) ? 1 : 0;
        end else if (sw_i) begin
            m_word = d_i;
            for (int k = 1; k < N; k++) begin
                r.sum = field_of(m_word, 0) + field_of(m_word, k);
                r.idx = k;
                m_pending.push_back(r);
            end
            m_out   = 0;
            m_valid = 0;
            m_busy  = 1;
        end else if (sel_i == 0) begin
            m_word  = d_i;
            m_out   = 0;
            m_valid = 0;
            m_fld   = 0;
            m_busy  = 0;
        end else if (sel_i < N) begin
            m_out   = field_of(m_word, 0) + field_of(m_word, sel_i);
            m_valid = 1;
            m_fld   = sel_i;
            m_busy  = 0;
`ifdef FIELD_SUM_ALL_EN
        end else if (sel_i == N) begin
            m_out = 0;
            for (int k = 0; k < N; k++) m_out += field_of(m_word, k);
            m_valid = 1;
            m_fld   = N;
            m_busy  = 0;
`endif
        end else begin
            m_out   = 0;
            m_valid = 0;
            m_fld   = sel_i;
            m_busy  = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic step(input logic [DATA_W-1:0] d_i, input int sel_i,
                        input bit sw_i, input bit rst_i);
        d     = d_i;
        sel   = SEL_W'(sel_i);
        sweep = sw_i;
        rst_n = rst_i;
        @(posedge clk);
        model_update(d_i, sel_i % (1 << SEL_W), sw_i, rst_i);
        #1;
        check("out",      32'(out),      m_out);
        check("validout", 32'(validout), m_valid);
        check("fld_idx",  32'(fld_idx),  m_fld);
        check("busy",     32'(busy),     m_busy);
    endtask

    int busy_cnt;
    bit hold_valid [8];

    initial begin
        d = '0; sel = '0; sweep = 1'b0; rst_n = 1'b0;
        hold_valid = '{0, 1, 1, 1, 0, 1, 1, 1};

        // Reset state
        step(16'hABCD, 2, 1'b1, 1'b0);
        step(16'hABCD, 2, 1'b0, 1'b0);
        check("rst_out", 32'(out), 0);
        check("rst_valid", 32'(validout), 0);

        // Latch 1234 and walk the pairwise selects
        step(16'h1234, 0, 1'b0, 1'b1);
        check("latch_valid", 32'(validout), 0);
        step(16'h1234, 1, 1'b0, 1'b1);
        check("tp_sel1", 32'(out), 7);
        step(16'h1234, 2, 1'b0, 1'b1);
        check("tp_sel2", 32'(out), 6);
        step(16'h1234, 3, 1'b0, 1'b1);
        check("tp_sel3", 32'(out), 5);
        check("tp_fld3", 32'(fld_idx), 3);

        // dreg is held while d changes without sel=0
        step(16'h2345, 0, 1'b0, 1'b1);
        step(16'h2345, 1, 1'b0, 1'b1);
        check("tp_2345_sel1", 32'(out), 9);
        step(16'hFFFF, 2, 1'b0, 1'b1);
        check("tp_hold_sel2", 32'(out), 8);

        // Maximum field values and the all-field select
        step(16'hFFFF, 0, 1'b0, 1'b1);
        step(16'hFFFF, 3, 1'b0, 1'b1);
        check("tp_ffff_sel3", 32'(out), 30);
        step(16'hFFFF, 4, 1'b0, 1'b1);
`ifdef FIELD_SUM_ALL_EN
        check("tp_all_out", 32'(out), 60);
        check("tp_all_valid", 32'(validout), 1);
`else
        check("tp_sel4_out", 32'(out), 0);
        check("tp_sel4_valid", 32'(validout), 0);
`endif
        step(16'hFFFF, 7, 1'b0, 1'b1);

        // Sweep pulse with random sel/d noise during the sweep
        step(16'h1234, 0, 1'b1, 1'b1);
        busy_cnt = busy ? 1 : 0;
        step(16'($urandom), $urandom_range(0, 7), 1'b0, 1'b1);
        check("sw_r1", 32'(out), 7);
        step(16'($urandom), $urandom_range(0, 7), 1'b0, 1'b1);
        check("sw_r2", 32'(out), 6);
        step(16'($urandom), $urandom_range(0, 7), 1'b0, 1'b1);
        check("sw_r3", 32'(out), 5);
        check("sw_busy_fall", 32'(busy), 0);

        // Bounded count of busy cycles for a second pulse
        step(16'h1234, 1, 1'b0, 1'b1);
        step(16'h5678, 0, 1'b1, 1'b1);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 10 && busy; i++) begin
            step(16'h0000, 0, 1'b0, 1'b1);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 3);

        // Sweep held high: one invalid gap between back-to-back sweeps
        for (int i = 0; i < 8; i++) begin
            step(16'h1234, $urandom_range(0, 7), 1'b1, 1'b1);
            check("hold_valid", 32'(validout), 32'(hold_valid[i]));
        end
        step(16'h1234, 0, 1'b0, 1'b1);
        step(16'h1234, 0, 1'b0, 1'b1);

        // Reset on the 2nd sweep cycle
        step(16'h1234, 0, 1'b1, 1'b1);
        step(16'h1234, 0, 1'b0, 1'b1);
        step(16'h1234, 0, 1'b0, 1'b0);
        check("midrst_out", 32'(out), 0);
        check("midrst_busy", 32'(busy), 0);
        step(16'h1234, 1, 1'b0, 1'b1);
        check("postrst_out", 32'(out), 0);
        check("postrst_valid", 32'(validout), 1);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(16'($urandom), $urandom_range(0, 7),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
